// File: rtl/key_sched_gen_if.sv
// Bundles the start/key request side and the subkey stream of key_sched_gen.
// Latency: none; this file only declares wires and their directions.
// Backpressure: the master drives sk_ready, and the slave holds sk/sk_round while it is low.
interface key_sched_gen_if #(
    parameter int NKEY = 3
);
    logic                   start;
    logic                   decrypt;
    logic [1:0]             key_sel;
    logic [64*NKEY-1:0]     key_in;
    logic                   busy;
    logic                   sk_valid;
    logic                   sk_ready;
    logic [47:0]            sk;
    logic [3:0]             sk_round;
    logic                   done;

    // master = requester/consumer, slave = schedule generator
    modport master (
        output start, decrypt, key_sel, key_in, sk_ready,
        input  busy, sk_valid, sk, sk_round, done
    );

    modport slave (
        input  start, decrypt, key_sel, key_in, sk_ready,
        output busy, sk_valid, sk, sk_round, done
    );
endinterface

// File: rtl/key_sched_gen.sv
// Generates the 16 DES round subkeys (PC-2 output) in encrypt or decrypt order.
// Latency: the first subkey is valid one cycle after start is accepted, then one per cycle; done follows 17 edges after acceptance.
// Backpressure: while sk_valid=1 and sk_ready=0, sk, sk_round, C/D and the round counter hold (STALL_EN=0 ignores sk_ready).
module key_sched_gen #(
    parameter int NKEY     = 3,
    parameter int STALL_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    key_sched_gen_if.slave    bus
);

    // PC-1: DES key bit numbers (1 = MSB) feeding C[1..28] then D[1..28]
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: CD bit numbers (1 = MSB of C) feeding subkey bits 1..48
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] res;
        for (int i = 0; i < 56; i++) begin
            res[55-i] = k[64-PC1_TAB[i]];
        end
        return res;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd_in);
        logic [47:0] res;
        for (int i = 0; i < 48; i++) begin
            res[47-i] = cd_in[56-PC2_TAB[i]];
        end
        return res;
    endfunction

    // amt is 0, 1 or 2; dir 0 rotates left (encrypt), 1 rotates right (decrypt)
    function automatic logic [27:0] rot28(input logic [27:0] x, input logic dir, input logic [1:0] amt);
        logic [27:0] res;
        case ({dir, amt})
            3'b001:  res = {x[26:0], x[27]};
            3'b010:  res = {x[25:0], x[27:26]};
            3'b101:  res = {x[0], x[27:1]};
            3'b110:  res = {x[1:0], x[27:2]};
            default: res = x;
        endcase
        return res;
    endfunction

    state_t      state, state_nxt;
    logic        dec_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  r_q;
    logic [47:0] sk_q;
    logic [3:0]  sk_round_q;
    logic        sk_valid_q;
    logic        done_q;

    logic        rdy;
    logic        accept;
    logic        issue;
    logic        last_taken;
    logic [63:0] slice;
    logic [55:0] cd_load;
    logic [1:0]  amt;
    logic [27:0] c_nxt, d_nxt;
    logic [47:0] sk_nxt;

    assign rdy = (STALL_EN != 0) ? bus.sk_ready : 1'b1;

    // Pick the requested 64-bit key slice; out-of-range selectors fall back to slice 0
    always_comb begin
        slice = bus.key_in[63:0];
        for (int n = 1; n < NKEY; n++) begin
            if (bus.key_sel == 2'(n)) begin
                slice = bus.key_in[64*n +: 64];
            end
        end
    end

    assign cd_load = pc1(slice);

    // Per-round rotation amount and the subkey that the next issue would produce
    always_comb begin
        amt = 2'd2;
        if (dec_q) begin
            if (r_q == 4'd0) begin
                amt = 2'd0;
            end else if (r_q == 4'd1 || r_q == 4'd8 || r_q == 4'd15) begin
                amt = 2'd1;
            end
        end else if (r_q == 4'd0 || r_q == 4'd1 || r_q == 4'd8 || r_q == 4'd15) begin
            amt = 2'd1;
        end
        c_nxt  = rot28(c_q, dec_q, amt);
        d_nxt  = rot28(d_q, dec_q, amt);
        sk_nxt = pc2({c_nxt, d_nxt});
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the accept/issue/last-accept strobes
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        issue      = 1'b0;
        last_taken = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!sk_valid_q || rdy) begin
                    issue = 1'b1;
                    if (r_q == 4'd15) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (sk_valid_q && rdy) begin
                    last_taken = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load C/D on accept, rotate and emit a subkey on each issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q      <= 1'b0;
            c_q        <= '0;
            d_q        <= '0;
            r_q        <= '0;
            sk_q       <= '0;
            sk_round_q <= '0;
            sk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= last_taken;
            if (accept) begin
                dec_q <= bus.decrypt;
                c_q   <= cd_load[55:28];
                d_q   <= cd_load[27:0];
                r_q   <= '0;
            end
            if (issue) begin
                c_q        <= c_nxt;
                d_q        <= d_nxt;
                sk_q       <= sk_nxt;
                sk_round_q <= r_q;
                r_q        <= r_q + 4'd1;
                sk_valid_q <= 1'b1;
            end else if (sk_valid_q && rdy) begin
                sk_valid_q <= 1'b0;
            end
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.sk_valid = sk_valid_q;
    assign bus.sk       = sk_q;
    assign bus.sk_round = sk_round_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_key_sched_gen.sv
// Directed bench for key_sched_gen with a scoreboard fed by an independent DES key-schedule model.
// Latency: checks done arrives 18 cycles after start is driven when the consumer never stalls.
// Backpressure: random sk_ready plus a 5-cycle hold at round 7; a STALL_EN=0 copy runs with sk_ready=0.
module tb_key_sched_gen;

    localparam logic [63:0] K0 = 64'h133457799BBCDFF1;
    localparam logic [63:0] K1 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] K2 = 64'h752878397493CB70;
    localparam logic [63:0] PAR = 64'h0101010101010101;

    localparam int M_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int M_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int M_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct packed {
        logic [3:0]  rnd;
        logic [47:0] sk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_sched_gen_if #(.NKEY(3)) ifa ();
    key_sched_gen_if #(.NKEY(3)) ifb ();

    key_sched_gen #(.NKEY(3), .STALL_EN(1)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    key_sched_gen #(.NKEY(3), .STALL_EN(0)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t qa[$];
    exp_t qb[$];

    bit          bp_mode = 1'b0;
    bit          rdy_val = 1'b1;
    bit          held7   = 1'b0;
    int          hold_cnt = 0;
    int          done_cnt = 0;
    int          stall_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [47:0] prev_sk;
    logic [3:0]  prev_rnd;
    logic [47:0] seen_r0;
    logic [47:0] seen_r15;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Textbook DES key schedule: Kn from cumulative left shifts of PC-1 halves
    function automatic logic [47:0] ref_key(input logic [63:0] key, input int n);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] k;
        int          total;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = key[64-M_PC1[i]];
            d[27-i] = key[64-M_PC1[i+28]];
        end
        total = 0;
        for (int i = 0; i < n; i++) total += M_SHIFT[i];
        for (int s = 0; s < total; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[47-i] = cd[56-M_PC2[i]];
        return k;
    endfunction

    task automatic push_sched(input logic [63:0] key, input bit dec, input bit to_b);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.rnd = 4'(i);
            e.sk  = dec ? ref_key(key, 16 - i) : ref_key(key, i + 1);
            if (to_b) qb.push_back(e);
            else      qa.push_back(e);
        end
    endtask

    // Consumer-ready driver: fixed level, or random with one long hold at round 7
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            if (hold_cnt > 0) begin
                ifa.sk_ready = 1'b0;
                hold_cnt--;
            end else if (!held7 && ifa.sk_valid && ifa.sk_round == 4'd7) begin
                held7 = 1'b1;
                hold_cnt = 4;
                ifa.sk_ready = 1'b0;
            end else begin
                ifa.sk_ready = 1'($urandom_range(0, 1));
            end
        end else begin
            ifa.sk_ready = rdy_val;
        end
    end

    // Scoreboard and stall monitor for the stalling instance
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                stall_cnt++;
                chk("stall_valid", 64'(ifa.sk_valid), 64'd1);
                chk("stall_sk", 64'(ifa.sk), 64'(prev_sk));
                chk("stall_round", 64'(ifa.sk_round), 64'(prev_rnd));
            end
            if (ifa.sk_valid && ifa.sk_ready) begin
                checks++;
                assert (qa.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_a_unexpected observed=round %0d expected=no output", ifa.sk_round);
                end
                if (qa.size() != 0) begin
                    e = qa.pop_front();
                    chk("sb_a_round", 64'(ifa.sk_round), 64'(e.rnd));
                    chk("sb_a_sk", 64'(ifa.sk), 64'(e.sk));
                end
                if (ifa.sk_round == 4'd0)  seen_r0  = ifa.sk;
                if (ifa.sk_round == 4'd15) seen_r15 = ifa.sk;
            end
            if (ifa.done) done_cnt++;
            prev_stall = ifa.sk_valid && !ifa.sk_ready;
            prev_sk    = ifa.sk;
            prev_rnd   = ifa.sk_round;
        end
    end

    // Scoreboard for the non-stalling instance: every valid cycle is a transfer
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ifb.sk_valid) begin
            checks++;
            assert (qb.size() != 0) else begin
                errors++;
                $error("FAIL sb_b_unexpected observed=round %0d expected=no output", ifb.sk_round);
            end
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("sb_b_round", 64'(ifb.sk_round), 64'(e.rnd));
                chk("sb_b_sk", 64'(ifb.sk), 64'(e.sk));
            end
        end
    end

    task automatic wait_done_a(inout int cyc);
        while (!ifa.done && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_a_seen", 64'(ifa.done), 64'd1);
        chk("busy_at_done", 64'(ifa.busy), 64'd0);
    endtask

    task automatic start_a(input bit dec, input logic [1:0] sel, input logic [191:0] key_after, output int cyc);
        ifa.decrypt = dec;
        ifa.key_sel = sel;
        ifa.start   = 1'b1;
        @(posedge clk); #1;
        ifa.start  = 1'b0;
        ifa.key_in = key_after;
        cyc = 1;
        chk("busy_after_start", 64'(ifa.busy), 64'd1);
    endtask

    task automatic wait_round_a(input logic [3:0] rnd);
        int n = 0;
        while (!(ifa.sk_valid && ifa.sk_round == rnd) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("round_reached", 64'(ifa.sk_round), 64'(rnd));
    endtask

    initial begin
        int cyc;
        int dc;
        ifa.start = 1'b0; ifa.decrypt = 1'b0; ifa.key_sel = 2'd0;
        ifa.key_in = {K2, K1, K0};
        ifa.sk_ready = 1'b1;
        ifb.start = 1'b0; ifb.decrypt = 1'b0; ifb.key_sel = 2'd0;
        ifb.key_in = {K2, K1, K0};
        ifb.sk_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(ifa.busy), 64'd0);
        chk("rst_valid", 64'(ifa.sk_valid), 64'd0);
        chk("rst_sk", 64'(ifa.sk), 64'd0);
        chk("rst_round", 64'(ifa.sk_round), 64'd0);
        chk("rst_done", 64'(ifa.done), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Encrypt, slice 0, full speed
        push_sched(K0, 1'b0, 1'b0);
        start_a(1'b0, 2'd0, {K2, K1, K0}, cyc);
        wait_done_a(cyc);
        chk("enc_done_cycle", 64'(cyc), 64'd18);
        chk("enc_r0", 64'(seen_r0), 64'h1B02EFFC7072);
        chk("enc_r15", 64'(seen_r15), 64'hCB3D8B0E17F5);
        chk("enc_drained", 64'(qa.size()), 64'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(ifa.done), 64'd0);

        // Decrypt, same key
        push_sched(K0, 1'b1, 1'b0);
        start_a(1'b1, 2'd0, {K2, K1, K0}, cyc);
        wait_done_a(cyc);
        chk("dec_done_cycle", 64'(cyc), 64'd18);
        chk("dec_r0", 64'(seen_r0), 64'hCB3D8B0E17F5);
        chk("dec_r15", 64'(seen_r15), 64'h1B02EFFC7072);
        chk("dec_drained", 64'(qa.size()), 64'd0);

        // Slice 2, with key_in scrambled right after acceptance
        push_sched(K2, 1'b0, 1'b0);
        start_a(1'b0, 2'd2, ~{K2, K1, K0}, cyc);
        wait_done_a(cyc);
        chk("sel2_drained", 64'(qa.size()), 64'd0);
        ifa.key_in = {K2, K1, K0};

        // Out-of-range selector falls back to slice 0
        push_sched(K0, 1'b0, 1'b0);
        start_a(1'b0, 2'd3, {K2, K1, K0}, cyc);
        wait_done_a(cyc);
        chk("sel3_drained", 64'(qa.size()), 64'd0);

        // Parity bits flipped on every slice: same subkeys
        ifa.key_in = {K2 ^ PAR, K1 ^ PAR, K0 ^ PAR};
        push_sched(K1, 1'b1, 1'b0);
        start_a(1'b1, 2'd1, {K2 ^ PAR, K1 ^ PAR, K0 ^ PAR}, cyc);
        wait_done_a(cyc);
        chk("parity_drained", 64'(qa.size()), 64'd0);
        ifa.key_in = {K2, K1, K0};

        // Random backpressure with a long hold at round 7
        bp_mode = 1'b1;
        push_sched(K1, 1'b0, 1'b0);
        start_a(1'b0, 2'd1, {K2, K1, K0}, cyc);
        wait_done_a(cyc);
        chk("bp_drained", 64'(qa.size()), 64'd0);
        chk("bp_hold_seen", 64'(held7), 64'd1);
        chk("bp_stalled_5", 64'(stall_cnt >= 5), 64'd1);
        bp_mode = 1'b0;
        @(posedge clk); #1;

        // start while busy is ignored at rounds 3 and 15
        push_sched(K0, 1'b0, 1'b0);
        start_a(1'b0, 2'd0, {K2, K1, K0}, cyc);
        wait_round_a(4'd3);
        ifa.start = 1'b1; ifa.decrypt = 1'b1; ifa.key_sel = 2'd2;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        cyc += 1;
        wait_round_a(4'd15);
        ifa.start = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0;
        cyc = 0;
        wait_done_a(cyc);
        chk("ignore_drained", 64'(qa.size()), 64'd0);

        // start in the done cycle begins a new schedule
        push_sched(K2, 1'b1, 1'b0);
        start_a(1'b1, 2'd2, {K2, K1, K0}, cyc);
        wait_done_a(cyc);
        chk("donecyc_done_cycle", 64'(cyc), 64'd18);
        chk("donecyc_drained", 64'(qa.size()), 64'd0);

        // STALL_EN=0 instance with sk_ready held low
        push_sched(K1, 1'b0, 1'b1);
        ifb.key_sel = 2'd1; ifb.decrypt = 1'b0; ifb.start = 1'b1;
        @(posedge clk); #1;
        ifb.start = 1'b0;
        cyc = 1;
        while (!ifb.done && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("nostall_done_cycle", 64'(cyc), 64'd18);
        chk("nostall_drained", 64'(qb.size()), 64'd0);

        // Reset mid-schedule aborts immediately, no done afterwards
        push_sched(K0, 1'b0, 1'b0);
        start_a(1'b0, 2'd0, {K2, K1, K0}, cyc);
        wait_round_a(4'd9);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(ifa.sk_valid), 64'd0);
        chk("arst_sk", 64'(ifa.sk), 64'd0);
        chk("arst_round", 64'(ifa.sk_round), 64'd0);
        chk("arst_busy", 64'(ifa.busy), 64'd0);
        chk("arst_done", 64'(ifa.done), 64'd0);
        qa.delete();
        dc = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("arst_no_done", 64'(done_cnt), 64'(dc));

        // First start after reset behaves normally
        push_sched(K2, 1'b0, 1'b0);
        start_a(1'b0, 2'd2, {K2, K1, K0}, cyc);
        wait_done_a(cyc);
        chk("post_rst_done_cycle", 64'(cyc), 64'd18);
        chk("post_rst_drained", 64'(qa.size()), 64'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
